// File: rtl/iir_section_sched.sv
// Sequencer for a shared first-order IIR section engine: walks a sample through up to
// NUM_SEC cascaded sections, with double-buffered coefficients and an engine watchdog.
module iir_section_sched #(
    parameter int NUM_SEC = 6,
    parameter int DW      = 65,
    parameter int CW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          sample_valid,
    input  logic [15:0]   sample_in,
    output logic          sample_ready,
    input  logic [2:0]    num_sec_cfg,
    input  logic          cfg_we,
    input  logic [4:0]    cfg_addr,
    input  logic [CW-1:0] cfg_wdata,
    input  logic          cfg_commit,
    output logic          eng_start,
    output logic [2:0]    eng_sel,
    output logic          eng_last,
    output logic [DW-1:0] eng_x,
    output logic [DW-1:0] eng_coef_a,
    output logic [DW-1:0] eng_coef_b,
    output logic [DW-1:0] eng_coef_c,
    output logic [DW-1:0] eng_coef_d,
    input  logic          eng_done,
    input  logic [DW-1:0] eng_y,
    output logic          out_valid,
    output logic [15:0]   out_y,
    output logic          busy,
    output logic          err_timeout,
    input  logic          err_clr
);
    localparam int              TW       = $clog2(TIMEOUT + 1);
    localparam logic [2:0]      NSEC_MAX = 3'(NUM_SEC);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} state_t;

    state_t               state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic [2:0]           nsec_q, nsec_d;
    logic [DW-1:0]        operand_q, operand_d;
    logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic                 pend_q, pend_d;
    logic                 err_q, err_d;
    logic signed [CW-1:0] shadow_q [NUM_SEC][4];
    logic signed [CW-1:0] shadow_d [NUM_SEC][4];
    logic signed [CW-1:0] active_q [NUM_SEC][4];
    logic signed [CW-1:0] active_d [NUM_SEC][4];
    logic signed [CW-1:0] sel_coef [4];
    logic                 accept;
    logic                 is_last;
    logic                 tmo_hit;

    function automatic logic [DW-1:0] sext_coef(input logic signed [CW-1:0] c);
        return {{(DW-CW){c[CW-1]}}, c};
    endfunction

    // Integer sample becomes a Q.16 operand.
    function automatic logic [DW-1:0] load_sample(input logic signed [15:0] s);
        return {{(DW-32){s[15]}}, s, 16'h0000};
    endfunction

    function automatic logic [2:0] clamp_nsec(input logic [2:0] n);
        if (n == 3'd0) return 3'd1;
        if (n > NSEC_MAX) return NSEC_MAX;
        return n;
    endfunction

    assign accept  = sample_ready && sample_valid;
    assign is_last = (idx_q == (nsec_q - 3'd1));
    assign tmo_hit = (state_q == WAIT) && !eng_done && (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT: begin
                if (eng_done)     state_d = is_last ? OUTPUT : ISSUE;
                else if (tmo_hit) state_d = IDLE;
            end
            OUTPUT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sample_ready = (state_q == IDLE) && resetn;
        busy         = (state_q != IDLE);
        eng_start    = (state_q == ISSUE);
        eng_last     = ((state_q == ISSUE) || (state_q == WAIT)) && is_last;
        out_valid    = (state_q == OUTPUT);
        eng_sel      = idx_q;
        eng_x        = operand_q;
        out_y        = operand_q[31:16];
        err_timeout  = err_q;
    end

    always_comb begin
        idx_d     = idx_q;
        nsec_d    = nsec_q;
        operand_d = operand_q;
        tmo_cnt_d = tmo_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    operand_d = load_sample(sample_in);
                    nsec_d    = clamp_nsec(num_sec_cfg);
                    idx_d     = 3'd0;
                end
            end
            ISSUE: tmo_cnt_d = '0;
            WAIT: begin
                if (eng_done) begin
                    operand_d = eng_y;
                    if (!is_last) idx_d = idx_q + 3'd1;
                end else if (!tmo_hit) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase

        err_d = err_q;
        if (err_clr) err_d = 1'b0;
        if (tmo_hit) err_d = 1'b1;

        shadow_d = shadow_q;
        if (cfg_we && (cfg_addr[4:2] < NSEC_MAX))
            shadow_d[cfg_addr[4:2]][cfg_addr[1:0]] = cfg_wdata;

        // The copy takes the post-write shadow so a same-cycle write is included.
        active_d = active_q;
        pend_d   = pend_q | cfg_commit;
        if ((state_q == IDLE) && pend_d) begin
            active_d = shadow_d;
            pend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            idx_q     <= '0;
            nsec_q    <= '0;
            operand_q <= '0;
            tmo_cnt_q <= '0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
            for (int s = 0; s < NUM_SEC; s++) begin
                for (int k = 0; k < 4; k++) begin
                    shadow_q[s][k] <= '0;
                    active_q[s][k] <= '0;
                end
            end
        end else begin
            idx_q     <= idx_d;
            nsec_q    <= nsec_d;
            operand_q <= operand_d;
            tmo_cnt_q <= tmo_cnt_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) sel_coef[k] = '0;
        if (idx_q < NSEC_MAX) begin
            for (int k = 0; k < 4; k++) sel_coef[k] = active_q[idx_q][k];
        end
    end

    assign eng_coef_a = sext_coef(sel_coef[0]);
    assign eng_coef_b = sext_coef(sel_coef[1]);
    assign eng_coef_c = sext_coef(sel_coef[2]);
    assign eng_coef_d = sext_coef(sel_coef[3]);

endmodule

// File: tb/tb_iir_section_sched.sv
// Bench for iir_section_sched: a behavioural engine responder plus directed and
// randomized scenarios checked against a plain-arithmetic cascade model.
module tb_iir_section_sched;
    localparam int DW = 65;
    localparam int M_ECHO = 0, M_ADD = 1, M_AFF = 2, M_NEVER = 3;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          sample_valid = 1'b0;
    logic [15:0]   sample_in = '0;
    logic          sample_ready;
    logic [2:0]    num_sec_cfg = '0;
    logic          cfg_we = 1'b0;
    logic [4:0]    cfg_addr = '0;
    logic [31:0]   cfg_wdata = '0;
    logic          cfg_commit = 1'b0;
    logic          eng_start;
    logic [2:0]    eng_sel;
    logic          eng_last;
    logic [DW-1:0] eng_x, eng_coef_a, eng_coef_b, eng_coef_c, eng_coef_d;
    logic          eng_done = 1'b0;
    logic [DW-1:0] eng_y = '0;
    logic          out_valid;
    logic [15:0]   out_y;
    logic          busy;
    logic          err_timeout;
    logic          err_clr = 1'b0;

    iir_section_sched dut (
        .clk(clk), .resetn(resetn), .sample_valid(sample_valid), .sample_in(sample_in),
        .sample_ready(sample_ready), .num_sec_cfg(num_sec_cfg), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
        .eng_start(eng_start), .eng_sel(eng_sel), .eng_last(eng_last), .eng_x(eng_x),
        .eng_coef_a(eng_coef_a), .eng_coef_b(eng_coef_b), .eng_coef_c(eng_coef_c),
        .eng_coef_d(eng_coef_d), .eng_done(eng_done), .eng_y(eng_y),
        .out_valid(out_valid), .out_y(out_y), .busy(busy), .err_timeout(err_timeout),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int acc_cyc = 0, out_cyc = 0, ov_count = 0;
    logic [15:0] out_y_l = '0;
    int eng_mode = M_ECHO;
    int eng_w = 1;
    int ecnt = 0;
    int stab_bad = 0;
    logic [DW-1:0] ex, ea, ed;
    logic el;
    logic [2:0] es;
    logic [2:0]    q_sel[$];
    logic          q_last[$];
    logic [DW-1:0] q_x[$];
    logic [DW-1:0] q_a[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Engine responder and event monitor, both evaluated mid-cycle.
    always @(negedge clk) begin
        if (sample_valid && sample_ready) acc_cyc = cyc;
        if (out_valid) begin
            out_cyc = cyc;
            ov_count++;
            out_y_l = out_y;
        end
        if (!resetn) begin
            eng_done = 1'b0;
            ecnt = 0;
        end else begin
            eng_done = 1'b0;
            if (eng_start) begin
                ex = eng_x; ea = eng_coef_a; ed = eng_coef_d; el = eng_last; es = eng_sel;
                q_sel.push_back(eng_sel); q_last.push_back(eng_last);
                q_x.push_back(eng_x); q_a.push_back(eng_coef_a);
                ecnt = eng_w;
            end else if (ecnt > 0) begin
                if (eng_x !== ex || eng_coef_a !== ea || eng_coef_d !== ed ||
                    eng_last !== el || eng_sel !== es) stab_bad++;
                ecnt--;
                if (ecnt == 0 && eng_mode != M_NEVER) begin
                    eng_done = 1'b1;
                    case (eng_mode)
                        M_ECHO:  eng_y = ex;
                        M_ADD:   eng_y = ex + 65'd65536;
                        default: eng_y = ex + ea + ed;
                    endcase
                end
            end
        end
    end

    task automatic clear_q();
        q_sel.delete(); q_last.delete(); q_x.delete(); q_a.delete();
    endtask

    task automatic cfg_write(input logic we, input logic [4:0] a, input logic [31:0] d,
                             input logic c);
        @(posedge clk); #1;
        cfg_we = we; cfg_addr = a; cfg_wdata = d; cfg_commit = c;
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_commit = 1'b0;
    endtask

    task automatic send(input logic [15:0] s, input logic [2:0] n);
        int k;
        @(posedge clk); #1;
        sample_valid = 1'b1; sample_in = s; num_sec_cfg = n;
        k = 0;
        do begin @(negedge clk); k++; end while (!sample_ready && k < 600);
        n_tests++;
        if (sample_ready !== 1'b1) begin
            n_fail++; $display("FAIL send_ready: sample_ready=%b required 1", sample_ready);
        end
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic wait_out(input int prev, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk); #1;
            if (ov_count > prev) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_tests++;
        if ({sample_ready, busy, eng_start, eng_last, out_valid, err_timeout} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: rdy/busy/start/last/ov/err=%b required 000000",
                {sample_ready, busy, eng_start, eng_last, out_valid, err_timeout});
        end
        n_tests++;
        if ({eng_x, eng_coef_a, eng_coef_d, out_y, eng_sel} !== '0) begin
            n_fail++; $display("FAIL reset_data: x=%h a=%h y=%h sel=%0d required 0",
                eng_x, eng_coef_a, out_y, eng_sel);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk); #1;
        n_tests++;
        if (sample_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b required 1", sample_ready);
        end
    endtask

    task automatic test_single();
        bit ok; int p; logic [DW-1:0] obs;
        eng_mode = M_ECHO; eng_w = 3; clear_q(); p = ov_count;
        send(16'd100, 3'd1);
        wait_out(p, 100, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL single_done: no out_valid seen"); end
        obs = (q_x.size() > 0) ? q_x[0] : 'x;
        n_tests++;
        if (obs !== (65'd100 << 16)) begin
            n_fail++; $display("FAIL single_x: eng_x=%h required %h", obs, 65'd100 << 16);
        end
        n_tests++;
        if (q_last.size() !== 1 || q_last[0] !== 1'b1) begin
            n_fail++; $display("FAIL single_last: starts=%0d required 1 with eng_last=1", q_last.size());
        end
        n_tests++;
        if (out_y_l !== 16'd100) begin
            n_fail++; $display("FAIL single_out_y: got %0d required 100", out_y_l);
        end
        n_tests++;
        if (out_cyc - acc_cyc + 1 !== 6) begin
            n_fail++; $display("FAIL single_latency: got %0d required 6", out_cyc - acc_cyc + 1);
        end
    endtask

    task automatic test_cascade();
        bit ok; int p;
        eng_mode = M_ADD; eng_w = 1; clear_q(); p = ov_count;
        send(16'd5, 3'd3);
        wait_out(p, 100, ok);
        n_tests++;
        if (q_sel.size() !== 3) begin
            n_fail++; $display("FAIL cascade_starts: got %0d required 3", q_sel.size());
        end
        for (int i = 0; i < q_sel.size(); i++) begin
            n_tests++;
            if (q_sel[i] !== 3'(i) || q_last[i] !== (i == 2)) begin
                n_fail++; $display("FAIL cascade_sel%0d: sel=%0d last=%b required sel=%0d last=%b",
                    i, q_sel[i], q_last[i], i, (i == 2));
            end
        end
        n_tests++;
        if (!ok || out_y_l !== 16'd8) begin
            n_fail++; $display("FAIL cascade_out_y: got %0d (seen=%b) required 8", out_y_l, ok);
        end
        n_tests++;
        if (out_cyc - acc_cyc + 1 !== 8) begin
            n_fail++; $display("FAIL cascade_latency: got %0d required 8", out_cyc - acc_cyc + 1);
        end
    endtask

    task automatic test_clamp();
        bit ok; int p; logic [15:0] s; int exp_n;
        eng_mode = M_ADD; eng_w = 1;
        for (int t = 0; t < 2; t++) begin
            exp_n = (t == 0) ? 1 : 6;
            s = 16'($urandom_range(0, 16'hffff));
            clear_q(); p = ov_count;
            send(s, (t == 0) ? 3'd0 : 3'd7);
            wait_out(p, 200, ok);
            n_tests++;
            if (q_sel.size() !== exp_n) begin
                n_fail++; $display("FAIL clamp_sections_%0d: got %0d required %0d", t, q_sel.size(), exp_n);
            end
            n_tests++;
            if (!ok || out_y_l !== 16'(s + 16'(exp_n)) || out_cyc - acc_cyc + 1 !== 2 + 2 * exp_n) begin
                n_fail++; $display("FAIL clamp_out_%0d: y=%h lat=%0d required y=%h lat=%0d", t,
                    out_y_l, out_cyc - acc_cyc + 1, 16'(s + 16'(exp_n)), 2 + 2 * exp_n);
            end
        end
    endtask

    task automatic test_commit_busy();
        bit ok; int p; logic [DW-1:0] obs;
        eng_mode = M_ECHO; eng_w = 6; clear_q(); p = ov_count;
        send(16'd1, 3'd1);
        repeat (2) @(negedge clk);
        cfg_write(1'b1, 5'd0, 32'd16, 1'b1);
        @(negedge clk); #1;
        n_tests++;
        if (busy !== 1'b1 || eng_coef_a !== '0) begin
            n_fail++; $display("FAIL commit_busy_hold: busy=%b a=%h required busy=1 a=0", busy, eng_coef_a);
        end
        wait_out(p, 100, ok);
        obs = (q_a.size() > 0) ? q_a[0] : 'x;
        n_tests++;
        if (obs !== '0) begin
            n_fail++; $display("FAIL commit_old_bank: a=%h required 0", obs);
        end
        clear_q(); p = ov_count; eng_w = 2;
        send(16'hffff, 3'd1);
        wait_out(p, 100, ok);
        obs = (q_a.size() > 0) ? q_a[0] : 'x;
        n_tests++;
        if (obs !== 65'd16) begin
            n_fail++; $display("FAIL commit_new_bank: a=%h required %h", obs, 65'd16);
        end
        obs = (q_x.size() > 0) ? q_x[0] : 'x;
        n_tests++;
        if (obs !== ({DW{1'b1}} << 16) || out_y_l !== 16'hffff) begin
            n_fail++; $display("FAIL commit_neg_x: x=%h y=%h required x=%h y=ffff",
                obs, out_y_l, {DW{1'b1}} << 16);
        end
    endtask

    task automatic test_timeout();
        int p; int wc;
        eng_mode = M_NEVER; eng_w = 1;
        for (int t = 0; t < 2; t++) begin
            err_clr = (t == 1);
            p = ov_count; wc = 0;
            send(16'd7, 3'd1);
            for (int i = 0; i < 400; i++) begin
                @(negedge clk); #1;
                if (!busy) break;
                if (!eng_start) wc++;
            end
            n_tests++;
            if (err_timeout !== 1'b1 || busy !== 1'b0) begin
                n_fail++; $display("FAIL timeout_flag_%0d: err=%b busy=%b required err=1 busy=0",
                    t, err_timeout, busy);
            end
            n_tests++;
            if (wc !== 255 || ov_count !== p) begin
                n_fail++; $display("FAIL timeout_wait_%0d: wait=%0d outs=%0d required 255 and 0",
                    t, wc, ov_count - p);
            end
            err_clr = 1'b0;
            @(posedge clk); #1; err_clr = 1'b1;
            @(posedge clk); #1; err_clr = 1'b0;
            n_tests++;
            if (err_timeout !== 1'b0) begin
                n_fail++; $display("FAIL timeout_clear_%0d: err=%b required 0", t, err_timeout);
            end
        end
    endtask

    task automatic test_reset_wait();
        bit ok; int p; int ns;
        cfg_write(1'b1, 5'd0, 32'h0003_0000, 1'b0);
        cfg_write(1'b1, 5'd3, 32'h0005_0000, 1'b1);
        eng_mode = M_AFF; eng_w = 10;
        send(16'd9, 3'd3);
        repeat (3) @(negedge clk);
        @(posedge clk); #1; resetn = 1'b0;
        @(posedge clk); #1; resetn = 1'b1;
        clear_q(); p = ov_count;
        @(negedge clk); #1;
        n_tests++;
        if (busy !== 1'b0 || eng_coef_a !== '0 || eng_coef_d !== '0 || eng_x !== '0) begin
            n_fail++; $display("FAIL rstwait_state: busy=%b a=%h d=%h x=%h required all 0",
                busy, eng_coef_a, eng_coef_d, eng_x);
        end
        repeat (30) @(negedge clk);
        ns = q_sel.size();
        n_tests++;
        if (ov_count !== p || ns !== 0) begin
            n_fail++; $display("FAIL rstwait_quiet: outs=%0d starts=%0d required 0 and 0", ov_count - p, ns);
        end
        cfg_write(1'b0, 5'd0, 32'd0, 1'b1);
        eng_w = 1; p = ov_count;
        send(16'd9, 3'd3);
        wait_out(p, 100, ok);
        n_tests++;
        if (!ok || out_y_l !== 16'd9) begin
            n_fail++; $display("FAIL rstwait_bank_zero: y=%0d seen=%b required 9", out_y_l, ok);
        end
    endtask

    task automatic test_random();
        bit ok; int p; int n, exp_n, w;
        logic signed [31:0] a_m [6];
        logic signed [31:0] d_m [6];
        logic signed [15:0] s;
        logic signed [DW-1:0] acc;
        eng_mode = M_AFF;
        for (int it = 0; it < 8; it++) begin
            for (int sec = 0; sec < 6; sec++) begin
                a_m[sec] = $urandom; d_m[sec] = $urandom;
                cfg_write(1'b1, {3'(sec), 2'd0}, a_m[sec], 1'b0);
                cfg_write(1'b1, {3'(sec), 2'd1}, $urandom, 1'b0);
                cfg_write(1'b1, {3'(sec), 2'd2}, $urandom, 1'b0);
                cfg_write(1'b1, {3'(sec), 2'd3}, d_m[sec], sec == 5);
            end
            n = (it == 0) ? 7 : $urandom_range(0, 7);
            exp_n = (n == 0) ? 1 : ((n > 6) ? 6 : n);
            w = $urandom_range(1, 4);
            s = 16'($urandom);
            acc = s;
            acc = acc <<< 16;
            for (int k = 0; k < exp_n; k++) acc = acc + a_m[k] + d_m[k];
            eng_w = w; clear_q(); p = ov_count;
            send(s, 3'(n));
            wait_out(p, 200, ok);
            n_tests++;
            if (!ok || out_y_l !== acc[31:16]) begin
                n_fail++; $display("FAIL random_%0d_out_y: got %h required %h (n=%0d)",
                    it, out_y_l, acc[31:16], n);
            end
            n_tests++;
            if (q_sel.size() !== exp_n || out_cyc - acc_cyc + 1 !== 2 + exp_n * (1 + w)) begin
                n_fail++; $display("FAIL random_%0d_timing: starts=%0d lat=%0d required %0d and %0d",
                    it, q_sel.size(), out_cyc - acc_cyc + 1, exp_n, 2 + exp_n * (1 + w));
            end
            for (int k = 0; k < q_a.size(); k++) begin
                n_tests++;
                if (q_a[k] !== DW'(a_m[k])) begin
                    n_fail++; $display("FAIL random_%0d_coef%0d: a=%h required %h",
                        it, k, q_a[k], DW'(a_m[k]));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_cascade();
        test_clamp();
        test_commit_busy();
        test_timeout();
        test_reset_wait();
        test_random();
        n_tests++;
        if (stab_bad !== 0) begin
            n_fail++; $display("FAIL operand_stability: %0d unstable WAIT cycles required 0", stab_bad);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/iir_section_sched.md
IIR_SECTION_SCHED -- requirements
Module: iir_section_sched

Interface
REQ-001 The block SHALL provide the following parameters (name, default, meaning):
- NUM_SEC, 6, maximum cascaded sections.
- DW, 65, datapath operand width.
- CW, 32, signed coefficient width.
- TIMEOUT, 255, maximum engine wait in cycles.

REQ-002 The block SHALL provide the following ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all logic on its rising edge.
- resetn, in, 1, synchronous active-low reset.
- sample_valid, in, 1, new input sample offered.
- sample_in, in, 16, signed integer input sample.
- sample_ready, out, 1, scheduler can accept a sample.
- num_sec_cfg, in, 3, number of active sections.
- cfg_we, in, 1, coefficient shadow write strobe.
- cfg_addr, in, 5, [4:2] section index, [1:0] coefficient select (0=a, 1=b, 2=c, 3=d).
- cfg_wdata, in, CW, signed coefficient value.
- cfg_commit, in, 1, request shadow-to-active bank copy.
- eng_start, out, 1, one-cycle start pulse to the shared section engine.
- eng_sel, out, 3, current section index.
- eng_last, out, 1, current section is the final first-order section.
- eng_x, out, DW, engine input operand.
- eng_coef_a/b/c/d, out, DW each, active coefficients sign-extended to DW.
- eng_done, in, 1, engine result valid.
- eng_y, in, DW, engine result.
- out_valid, out, 1, one-cycle filtered-output strobe.
- out_y, out, 16, filtered output, operand bits [31:16].
- busy, out, 1, FSM not in IDLE.
- err_timeout, out, 1, sticky engine-timeout flag.
- err_clr, in, 1, clears err_timeout.

Function
REQ-003 The FSM SHALL use states IDLE, ISSUE, WAIT, OUTPUT.
REQ-004 sample_ready SHALL be 1 only in IDLE; a sample is accepted on a cycle with sample_valid=1 and sample_ready=1.
REQ-005 On acceptance the block SHALL:
- Load operand = sign-extend(sample_in) placed at bits [31:16], with bits [15:0]=0 (Q.16).
- Latch nsec = clamp(num_sec_cfg, 1, NUM_SEC); a value of 0 SHALL be treated as 1.
- Set idx=0 and go to ISSUE.
REQ-006 ISSUE SHALL last exactly one cycle and SHALL:
- Drive eng_start=1, eng_sel=idx, eng_x=operand, eng_last=(idx==nsec-1), and the active-bank coefficients of section idx.
- Go to WAIT.
REQ-007 eng_x, eng_sel, eng_last and eng_coef_* SHALL be held stable from ISSUE through the cycle eng_done is seen.
REQ-008 In WAIT, when eng_done=1 the block SHALL capture eng_y into operand, then:
- if idx==nsec-1, go to OUTPUT;
- otherwise, increment idx and go to ISSUE.
REQ-009 eng_done SHALL be ignored outside WAIT.
REQ-010 OUTPUT SHALL last one cycle with out_valid=1 and out_y=operand[31:16], then go to IDLE.
REQ-011 Latency SHALL be 2 + sum over sections of (1 + Wk) cycles from the accept edge to the out_valid edge, where Wk is the WAIT-cycle count including the done cycle.
REQ-012 Timeout handling SHALL work as follows:
- A WAIT counter resets on each ISSUE.
- If TIMEOUT cycles elapse in WAIT without eng_done, err_timeout SHALL set and the FSM SHALL go to IDLE with no out_valid for that sample.
REQ-013 err_clr SHALL clear err_timeout; a timeout in the same cycle as err_clr SHALL win (flag stays 1).
REQ-014 cfg_we SHALL write the shadow bank in any state; writes to section indices >= NUM_SEC SHALL be ignored.
REQ-015 cfg_commit SHALL set a pending flag, and the commit SHALL complete as follows:
- Pending is applied (full shadow copied to active) on the first IDLE cycle.
- A sample accepted in that same cycle SHALL use the new bank.
- The active bank SHALL never change while busy=1.
REQ-016 If cfg_we and a commit apply in the same cycle, the copied bank SHALL include that write.
REQ-017 Coefficients SHALL be sign-extended from CW to DW; no rounding or saturation is performed in this block.

Reset
REQ-018 With resetn=0 at a clk edge, the block SHALL enter IDLE and clear the following to 0:
- idx, operand, nsec, the timeout counter, the commit-pending flag, and both coefficient banks.
- All outputs: eng_start, eng_sel, eng_last, eng_x, eng_coef_*, out_valid, out_y, busy, err_timeout.
- sample_ready SHALL be 0 during reset and 1 on the first cycle after release.
REQ-019 Reset asserted mid-sequence SHALL abort the sequence immediately: no out_valid and no further eng_start.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Single section: nsec=1, engine echoes eng_x with W=3, sample_in=100 -> eng_x=100<<16, eng_last=1, out_y=100, out_valid 6 cycles after accept.
- Cascade: num_sec_cfg=3, engine returns eng_x+65536 with W=1 -> eng_sel 0,1,2; eng_last only on section 2; sample_in=5 gives out_y=8; latency 8.
- Clamp: num_sec_cfg=0 -> one section; num_sec_cfg=7 -> six sections.
- Commit while busy: write a_0=16, commit mid-sequence -> current sample sees old a_0=0; next sample sees eng_coef_a=16; sample_in=-1 gives eng_x=all ones above bit 15.
- Timeout: engine never asserts done -> err_timeout=1 after 255 WAIT cycles, FSM in IDLE, no out_valid; err_clr -> 0.
- Reset in WAIT: resetn=0 for 1 cycle -> busy=0, out_valid never pulses, bank contents zero.
